clock_phase_gen: RTL and testbench

CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

---
 rtl/clock_phase_gen_if.sv | 13 +
 rtl/clock_phase_gen.sv | 156 +++++++++++++++
 tb/tb_clock_phase_gen.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_phase_gen_if.sv
// rtl/clock_phase_gen_if.sv - configuration write handshake for clock_phase_gen
interface clock_phase_gen_if #(
    parameter int CNT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_phase;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clock_phase_gen.sv
// rtl/clock_phase_gen.sv - multi-channel divided clock generator with per-channel
// start phase and glitch-free stop.
module clock_phase_gen #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    clock_phase_gen_if.slave  cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] strobe,
    output logic              locked,
    output logic [1:0]        state_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOP    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic              armed_q;
    logic              cfg_fire;
    logic              all_low;
    logic [CNT_W-1:0]  div_q   [NUM_CH];
    logic [CNT_W-1:0]  phase_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_n   [NUM_CH];
    logic [CNT_W-1:0]  wait_q  [NUM_CH];
    logic [CNT_W-1:0]  wait_n  [NUM_CH];
    logic [NUM_CH-1:0] clk_n;
    logic [NUM_CH-1:0] terminal;
    logic [NUM_CH-1:0] waiting;

    // A zero divide behaves as one: terminal count is then reached every cycle.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] eff_div;
        assign eff_div     = (div_q[g] == '0) ? CNT_W'(1) : div_q[g];
        assign terminal[g] = (cnt_q[g] == eff_div - CNT_W'(1));
        assign waiting[g]  = (wait_q[g] != '0);
    end

    // armed_q keeps cfg_ready low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign cfg.cfg_ready = armed_q && (state_q == IDLE);
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign all_low       = (clk_out == '0);
    assign locked        = (state_q == RUN) && (waiting == '0);
    assign state_o       = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= CNT_W'(1);
                phase_q[i] <= '0;
            end
        end else if (cfg_fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg.cfg_ch == 3'(i)) begin
                    div_q[i]   <= cfg.cfg_div;
                    phase_q[i] <= cfg.cfg_phase;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (run)     state_n = RUN;
            RUN:     if (!run)    state_n = STOP;
            STOP:    if (all_low) state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    // Per-channel next state; in STOP only channels still high keep counting.
    always_comb begin
        clk_n = clk_out;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_n[i]  = cnt_q[i];
            wait_n[i] = wait_q[i];
            case (state_q)
                IDLE: begin
                    cnt_n[i]  = '0;
                    clk_n[i]  = 1'b0;
                    wait_n[i] = run ? phase_q[i] : '0;
                end
                RUN: begin
                    if (waiting[i]) begin
                        wait_n[i] = wait_q[i] - CNT_W'(1);
                        clk_n[i]  = 1'b0;
                    end else if (terminal[i]) begin
                        cnt_n[i] = '0;
                        clk_n[i] = ~clk_out[i];
                    end else begin
                        cnt_n[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (all_low) begin
                        cnt_n[i]  = '0;
                        wait_n[i] = '0;
                    end else if (clk_out[i]) begin
                        if (terminal[i]) begin
                            cnt_n[i] = '0;
                            clk_n[i] = 1'b0;
                        end else begin
                            cnt_n[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    cnt_n[i]  = '0;
                    wait_n[i] = '0;
                    clk_n[i]  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_out <= '0;
            strobe  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                wait_q[i] <= '0;
            end
        end else begin
            clk_out <= clk_n;
            strobe  <= clk_n & ~clk_out;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_n[i];
                wait_q[i] <= wait_n[i];
            end
        end
    end
endmodule

// File: tb/tb_clock_phase_gen.sv
// tb/tb_clock_phase_gen.sv - self-checking bench for clock_phase_gen
module tb_clock_phase_gen;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;

    logic              clock;
    logic              reset;
    logic              run;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] strobe;
    logic              locked;
    logic [1:0]        state_o;

    clock_phase_gen_if #(.CNT_W(CNT_W)) cfg_bus ();

    clock_phase_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .cfg     (cfg_bus),
        .clk_out (clk_out),
        .strobe  (strobe),
        .locked  (locked),
        .state_o (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int div;
        int phase;
        int first_rise;
        int period;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time-since-start arithmetic rather than counters.
    int                m_div   [NUM_CH];
    int                m_phase [NUM_CH];
    int                m_state;
    int                m_k;
    bit                m_armed;
    logic [NUM_CH-1:0] m_clk;
    logic [NUM_CH-1:0] m_strobe;
    logic [NUM_CH-1:0] m_stop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_clk(input int i, input int k);
        int d;
        int p;
        d = (m_div[i] == 0) ? 1 : m_div[i];
        p = m_phase[i];
        if (k < p) return 1'b0;
        return (((k - p) / d) % 2) == 1;
    endfunction

    function automatic bit exp_locked();
        int maxp;
        maxp = 0;
        for (int i = 0; i < NUM_CH; i++) if (m_phase[i] > maxp) maxp = m_phase[i];
        return (m_state == 1) && (m_k >= maxp);
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_k      = 0;
        m_armed  = 1'b0;
        m_clk    = '0;
        m_strobe = '0;
        m_stop   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]   = 1;
            m_phase[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] prev;
        bit                ready_pre;
        int                c;
        prev      = m_clk;
        ready_pre = m_armed && (m_state == 0);
        m_armed   = 1'b1;
        case (m_state)
            0: begin
                c = int'(cfg_bus.cfg_ch);
                if (cfg_bus.cfg_valid && ready_pre && c < NUM_CH) begin
                    m_div[c]   = int'(cfg_bus.cfg_div);
                    m_phase[c] = int'(cfg_bus.cfg_phase);
                end
                if (run) begin
                    m_state = 1;
                    m_k     = 0;
                end
                m_clk = '0;
            end
            1: begin
                m_k++;
                for (int i = 0; i < NUM_CH; i++) m_clk[i] = f_clk(i, m_k);
                if (!run) begin
                    m_state = 2;
                    m_stop  = m_clk;
                end
            end
            default: begin
                if (m_clk == '0) begin
                    m_state = 0;
                end else begin
                    m_k++;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (m_stop[i]) begin
                            m_clk[i] = f_clk(i, m_k);
                            if (!m_clk[i]) m_stop[i] = 1'b0;
                        end
                    end
                end
            end
        endcase
        m_strobe = m_clk & ~prev;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("clk_out",   clk_out,           m_clk);
        chk("strobe",    strobe,            m_strobe);
        chk("locked",    locked,            exp_locked());
        chk("state",     state_o,           m_state);
        chk("cfg_ready", cfg_bus.cfg_ready, m_armed && (m_state == 0));
    endtask

    task automatic cfg_write(input int ch, input int dv, input int ph);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'(ch);
        cfg_bus.cfg_div   = 4'(dv);
        cfg_bus.cfg_phase = 4'(ph);
        cycle();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        cycle();
    endtask

    task automatic wait_idle();
        run = 1'b0;
        for (int n = 0; n < 40 && m_state != 0; n++) cycle();
        chk("idle_reached", state_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int first;
        int second;
        int n;
        int hi;
        int len;
        logic prev;

        vecs[0] = '{0, 1,  0,  1,  2};
        vecs[1] = '{1, 3,  2,  5,  6};
        vecs[2] = '{2, 0,  0,  1,  2};
        vecs[3] = '{0, 4,  0,  4,  8};
        vecs[4] = '{2, 15, 15, 30, 30};
        vecs[5] = '{1, 2,  7,  9,  4};

        reset = 1'b0;
        run   = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_phase = '0;
        model_reset();
        #3;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_strobe",  strobe,  0);
        chk("rst_locked",  locked,  0);
        chk("rst_state",   state_o, 0);
        chk("rst_ready",   cfg_bus.cfg_ready, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        cycle();
        chk("ready_after_release", cfg_bus.cfg_ready, 1);

        // Table: first rise and period per configuration.
        foreach (vecs[v]) begin
            first  = -1;
            second = -1;
            cfg_write(vecs[v].ch, vecs[v].div, vecs[v].phase);
            run = 1'b1;
            cycle();
            prev = clk_out[vecs[v].ch];
            for (int k = 1; k <= 100 && second < 0; k++) begin
                cycle();
                if (clk_out[vecs[v].ch] && !prev) begin
                    if (first < 0) first = k;
                    else           second = k;
                end
                prev = clk_out[vecs[v].ch];
            end
            chk($sformatf("vec%0d_first_rise", v), first, vecs[v].first_rise);
            chk($sformatf("vec%0d_period", v), second - first, vecs[v].period);
            wait_idle();
        end

        // Stop one cycle after a rise: pulse must stay full width.
        do_reset();
        cfg_write(0, 4, 0);
        run = 1'b1;
        cycle();
        n = 0;
        while (clk_out[0] !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk("stop_rise_seen", clk_out[0], 1);
        hi  = 1;
        run = 1'b0;
        for (int n2 = 0; n2 < 20; n2++) begin
            cycle();
            if (clk_out[0]) hi++;
            else break;
        end
        chk("stop_high_len", hi, 4);
        chk("stop_state_after_fall", state_o, 2);
        cycle();
        chk("stop_to_idle", state_o, 0);

        // Out-of-range channel write and a write attempt during RUN.
        do_reset();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'd5;
        cfg_bus.cfg_div   = 4'd7;
        cfg_bus.cfg_phase = 4'd9;
        #1;
        chk("oob_ready", cfg_bus.cfg_ready, 1);
        cycle();
        cfg_bus.cfg_valid = 1'b0;
        run = 1'b1;
        cycle();
        cycle();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'd0;
        cfg_bus.cfg_div   = 4'd9;
        cfg_bus.cfg_phase = 4'd3;
        #1;
        chk("run_ready_low", cfg_bus.cfg_ready, 0);
        cycle();
        cycle();
        cfg_bus.cfg_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        wait_idle();

        // Asynchronous reset mid-RUN while clk_out is high.
        cfg_write(1, 5, 3);
        run = 1'b1;
        cycle();
        n = 0;
        while (clk_out[0] !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        #2 reset = 1'b0;
        run = 1'b0;
        model_reset();
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_strobe",  strobe,  0);
        chk("arst_locked",  locked,  0);
        chk("arst_state",   state_o, 0);
        chk("arst_ready",   cfg_bus.cfg_ready, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        cycle();
        run = 1'b1;
        cycle();
        cycle();
        chk("arst_default_ch1_rise", clk_out[1], 1);
        chk("arst_default_locked", locked, 1);
        for (int k = 0; k < 5; k++) cycle();
        wait_idle();

        // Randomized sessions against the reference model.
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(1, 3);
            for (int w = 0; w < n; w++)
                cfg_write($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            n = $urandom_range(0, 2);
            for (int w = 0; w < n; w++) cycle();
            run = 1'b1;
            len = $urandom_range(1, 60);
            for (int l = 0; l < len; l++) begin
                cycle();
                cfg_bus.cfg_valid = ($urandom_range(0, 3) == 0);
                cfg_bus.cfg_ch    = 3'($urandom_range(0, 7));
                cfg_bus.cfg_div   = 4'($urandom_range(0, 15));
                cfg_bus.cfg_phase = 4'($urandom_range(0, 15));
            end
            cfg_bus.cfg_valid = 1'b0;
            run = 1'b0;
            for (int s = 0; s < 60 && m_state != 0; s++) begin
                run = (m_state == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                cycle();
            end
            run = 1'b0;
            cycle();
            chk("rand_idle", state_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
